// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl shared definitions:
// opcodes, FSM states, datapath width.
package alu_issue_ctrl_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_MUL4 = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_ZERO = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file: two async read ports and
// one write port shared by load and write-back.
module alu_regfile
  import alu_issue_ctrl_pkg::*;
#(
  parameter int N_REGS = 4,
  localparam int IDX_W = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wb_we,
  input  logic [IDX_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [IDX_W-1:0]  ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IDX_W-1:0]  rb_addr,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] rf [N_REGS];

  // Write-back wins; the controller never
  // lets both fire together anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++)
        rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_addr] <= wb_data;
    end else if (ld_we) begin
      rf[ld_addr] <= ld_data;
    end
  end

  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand issue / write-back controller for
// an external combinational 8-bit ALU.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int N_REGS = 4,
  localparam int IDX_W = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IDX_W-1:0]  in_rd,
  input  logic [IDX_W-1:0]  in_rs1,
  input  logic [IDX_W-1:0]  in_rs2,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        opcode,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [IDX_W-1:0]  res_rd,
  output logic              res_zero
);

  state_t state_q, state_d;

  logic [IDX_W-1:0]  rd_q;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              in_acc;
  logic              ld_acc;
  logic              wb_we;

  assign in_acc = in_valid && in_ready;
  assign ld_acc = ld_valid && ld_ready;

  alu_regfile #(
    .N_REGS(N_REGS)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_we  (ld_acc),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .wb_we  (wb_we),
    .wb_addr(rd_q),
    .wb_data(alu_out),
    .ra_addr(in_rs1),
    .ra_data(ra_data),
    .rb_addr(in_rs2),
    .rb_data(rb_data)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    ld_ready  = 1'b0;
    res_valid = 1'b0;
    wb_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        ld_ready = 1'b1;
        if (in_acc)
          state_d = EXEC;
      end
      EXEC: begin
        wb_we   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands read pre-load rf contents:
  // the load lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      A        <= '0;
      B        <= '0;
      opcode   <= '0;
      rd_q     <= '0;
      res_data <= '0;
      res_rd   <= '0;
      res_zero <= 1'b1;
    end else begin
      state_q <= state_d;
      if (in_acc) begin
        A      <= ra_data;
        B      <= rb_data;
        opcode <= in_op;
        rd_q   <= in_rd;
      end
      if (wb_we) begin
        res_data <= alu_out;
        res_zero <= (alu_out == '0);
        res_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl:
// directed cases plus randomized traffic.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [IW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [IW-1:0] in_rd = '0;
  logic [IW-1:0] in_rs1 = '0;
  logic [IW-1:0] in_rs2 = '0;
  logic [7:0]    A, B;
  logic [2:0]    opcode;
  logic [7:0]    alu_out;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [7:0]    res_data;
  logic [IW-1:0] res_rd;
  logic          res_zero;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .A(A), .B(B), .opcode(opcode),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd),
    .res_zero(res_zero)
  );

  function automatic logic [7:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op
  );
    logic [7:0] r;
    case (op)
      OP_NOT:  r = ~a;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_MUL4: r = {4'h0, a[3:0]} * {4'h0, b[3:0]};
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign alu_out = alu_f(A, B, opcode);

  function automatic void chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endfunction

  // Reference: an instruction in flight, then a
  // pending result, else idle and accepting.
  logic [7:0]    m_rf [NR];
  logic [7:0]    m_a, m_b, m_res;
  logic [2:0]    m_op;
  logic [IW-1:0] m_rd, m_res_rd;
  logic          m_zero;
  bit            m_exec, m_valid;

  always @(posedge clk) begin : model
    logic [7:0] r;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_rf[i] = 8'h00;
      m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
      m_res = 0; m_res_rd = 0; m_zero = 1;
      m_exec = 0; m_valid = 0;
    end else if (m_exec) begin
      r = alu_f(m_a, m_b, m_op);
      m_rf[m_rd] = r;
      m_res = r;
      m_zero = (r == 8'h00);
      m_res_rd = m_rd;
      m_exec = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (res_ready) m_valid = 0;
    end else begin
      if (in_valid) begin
        m_a = m_rf[in_rs1];
        m_b = m_rf[in_rs2];
        m_op = in_op;
        m_rd = in_rd;
        m_exec = 1;
      end
      if (ld_valid) m_rf[ld_addr] = ld_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !m_exec && !m_valid);
      chk("ld_ready", ld_ready, !m_exec && !m_valid);
      chk("res_valid", res_valid, m_valid);
      chk("A", A, m_a);
      chk("B", B, m_b);
      chk("opcode", opcode, m_op);
      chk("res_data", res_data, m_res);
      chk("res_rd", res_rd, m_res_rd);
      chk("res_zero", res_zero, m_zero);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] a,
                      input logic [7:0] d);
    ld_valid = 1; ld_addr = a; ld_data = d;
    cyc();
    ld_valid = 0;
  endtask

  task automatic wait_res(output logic [7:0] d);
    int n = 0;
    while (!res_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("res_timeout", res_valid, 1);
    d = res_data;
  endtask

  task automatic run(input logic [2:0] op,
                     input logic [IW-1:0] rd,
                     input logic [IW-1:0] s1,
                     input logic [IW-1:0] s2,
                     output logic [7:0] d);
    in_valid = 1; in_op = op;
    in_rd = rd; in_rs1 = s1; in_rs2 = s2;
    cyc();
    in_valid = 0;
    wait_res(d);
    cyc();
  endtask

  task automatic readreg(input logic [IW-1:0] r,
                         input logic [7:0] exp,
                         input string nm);
    logic [7:0] d;
    run(OP_OR, r, r, r, d);
    chk(nm, d, exp);
  endtask

  initial begin
    logic [7:0] d;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_zero", res_zero, 1);
    chk("rst_res_valid", res_valid, 0);
    rst_n = 1;

    load(1, 8'h0F);
    load(2, 8'h0E);
    in_valid = 1; in_op = OP_MUL4;
    in_rd = 3; in_rs1 = 1; in_rs2 = 2;
    cyc();
    in_valid = 0;
    chk("mul_A", A, 8'h0F);
    chk("mul_B", B, 8'h0E);
    chk("mul_early_valid", res_valid, 0);
    cyc();
    chk("mul_valid", res_valid, 1);
    chk("mul_data", res_data, 8'hD2);
    chk("mul_rd", res_rd, 3);
    chk("mul_zero", res_zero, 0);
    cyc();
    readreg(3, 8'hD2, "mul_rf3");

    load(0, 8'hFF);
    load(1, 8'h01);
    run(OP_ADD, 2, 0, 1, d);
    chk("add_data", d, 8'h00);
    chk("add_zero", res_zero, 1);
    readreg(2, 8'h00, "add_rf2");

    res_ready = 0;
    in_valid = 1; in_op = OP_XOR;
    in_rd = 3; in_rs1 = 0; in_rs2 = 1;
    cyc();
    cyc();
    ld_valid = 1; ld_addr = 0; ld_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_ld_ready", ld_ready, 0);
      chk("bp_A", A, 8'hFF);
      chk("bp_B", B, 8'h01);
      chk("bp_op", opcode, OP_XOR);
      chk("bp_data", res_data, 8'hFE);
      cyc();
    end
    in_valid = 0; ld_valid = 0; res_ready = 1;
    cyc();
    chk("bp_release", in_ready, 1);
    chk("bp_valid_drop", res_valid, 0);
    readreg(0, 8'hFF, "bp_no_load");
    readreg(3, 8'hFE, "bp_rf3");

    load(1, 8'h05);
    ld_valid = 1; ld_addr = 1; ld_data = 8'hAA;
    in_valid = 1; in_op = OP_SUB;
    in_rd = 0; in_rs1 = 1; in_rs2 = 1;
    cyc();
    ld_valid = 0; in_valid = 0;
    chk("sim_A", A, 8'h05);
    chk("sim_B", B, 8'h05);
    wait_res(d);
    chk("sim_data", d, 8'h00);
    cyc();
    readreg(1, 8'hAA, "sim_rf1");

    load(1, 8'h03);
    load(2, 8'h04);
    run(OP_ADD, 1, 1, 2, d);
    chk("dep_first", d, 8'h07);
    run(OP_ADD, 1, 1, 2, d);
    chk("dep_second", d, 8'h0B);

    res_ready = 0;
    in_valid = 1; in_op = OP_OR;
    in_rd = 2; in_rs1 = 1; in_rs2 = 2;
    cyc();
    in_valid = 0;
    cyc();
    chk("rd_in_done", res_valid, 1);
    rst_n = 0;
    cyc();
    rst_n = 1; res_ready = 1;
    chk("rd_valid", res_valid, 0);
    chk("rd_A", A, 8'h00);
    chk("rd_B", B, 8'h00);
    chk("rd_op", opcode, 0);
    chk("rd_in_ready", in_ready, 1);
    for (int r = 0; r < NR; r++)
      readreg(r[IW-1:0], 8'h00, "rd_rf_clear");

    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      in_valid  = $urandom_range(0, 1) != 0;
      ld_valid  = $urandom_range(0, 1) != 0;
      res_ready = $urandom_range(0, 3) != 0;
      in_op     = 3'($urandom_range(0, 7));
      in_rd     = IW'($urandom_range(0, NR - 1));
      in_rs1    = IW'($urandom_range(0, NR - 1));
      in_rs2    = IW'($urandom_range(0, NR - 1));
      ld_addr   = IW'($urandom_range(0, NR - 1));
      ld_data   = 8'($urandom_range(0, 255));
      cyc();
    end
    rst_n = 1; in_valid = 0; ld_valid = 0;
    res_ready = 1;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
